// File: rtl/req_pend_if.sv
// Request/offer/acknowledge bundle between the request-capture stage,
// its request sources and the downstream priority encoder.
interface req_pend_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]         req_in;
    logic [N_REQ-1:0]         mask;
    logic [N_REQ-1:0]         pend_out;
    logic                     pend_valid;
    logic                     ack;
    logic [$clog2(N_REQ)-1:0] ack_idx;
    logic [N_REQ-1:0]         ovf;
    logic                     ovf_clr;
    logic                     tmo;

    modport master (output req_in, mask, ack, ack_idx, ovf_clr,
                    input  pend_out, pend_valid, ovf, tmo);
    modport slave  (input  req_in, mask, ack, ack_idx, ovf_clr,
                    output pend_out, pend_valid, ovf, tmo);
endinterface

// File: rtl/req_pend_latch.sv
// Rising-edge request capture with sticky pending bits, presented to the
// priority encoder as a frozen snapshot under a valid/ack handshake.
module req_pend_latch #(
    parameter int N_REQ = 4,
    parameter int TMO_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    req_pend_if.slave bus
);
    localparam logic [TMO_W-1:0] CNT_LAST = {TMO_W{1'b1}};

    typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_REQ-1:0] r_req_d, r_pend, r_snap, r_ovf;
    logic [N_REQ-1:0] w_snap_nxt;
    logic [TMO_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_tmo, w_tmo_nxt;
    logic [N_REQ-1:0] w_edge, w_clr, w_unmasked;
    logic             w_ack_ok;

    assign w_edge     = bus.req_in & ~r_req_d;
    assign w_unmasked = r_pend & ~bus.mask;
    // Only an ack naming a bit of the frozen snapshot retires a request.
    assign w_ack_ok   = (r_state == S_OFFER) && bus.ack && r_snap[bus.ack_idx];
    assign w_clr      = w_ack_ok ? (N_REQ'(1) << bus.ack_idx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_snap_nxt  = r_snap;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_unmasked) begin
                    w_state_nxt = S_OFFER;
                    w_snap_nxt  = w_unmasked;
                    w_cnt_nxt   = '0;
                end
            end
            S_OFFER: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_ack_ok) begin
                    w_state_nxt = S_IDLE;
                end else if (w_cnt_nxt == CNT_LAST) begin
                    // Abandon after 2^TMO_W-1 offer cycles; an ack on that cycle wins.
                    w_state_nxt = S_IDLE;
                    w_tmo_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req_d <= '0;
            r_pend  <= '0;
            r_snap  <= '0;
            r_ovf   <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req_d <= bus.req_in;
            // New edges take priority over the acknowledge clear.
            r_pend  <= (r_pend & ~w_clr) | w_edge;
            r_ovf   <= (r_ovf & ~{N_REQ{bus.ovf_clr}}) | (w_edge & r_pend & ~w_clr);
            r_snap  <= w_snap_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    assign bus.pend_valid = (r_state == S_OFFER);
    assign bus.pend_out   = (r_state == S_OFFER) ? r_snap : '0;
    assign bus.ovf        = r_ovf;
    assign bus.tmo        = r_tmo;
endmodule

// File: tb/tb_req_pend_latch.sv
// Directed and random bench for req_pend_latch against a cycle-level
// behavioural model of the pending/offer rules.
module tb_req_pend_latch;
    localparam int TMO_W   = 3;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    req_pend_if #(.N_REQ(4)) bus();

    req_pend_latch #(.N_REQ(4), .TMO_W(TMO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] m_pend, m_prev, m_ovf, m_snap;
    bit         m_offering, m_tmo;
    int         m_age;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_ovf = '0; m_snap = '0;
        m_offering = 0; m_tmo = 0; m_age = 0;
    endtask

    task automatic model_update();
        logic [3:0] clr, nxt_pend;
        bit         accepted;
        clr = '0;
        accepted = m_offering && bus.ack && m_snap[bus.ack_idx];
        if (accepted) clr[bus.ack_idx] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bit rise;
            rise = bus.req_in[b] && !m_prev[b];
            if (rise && m_pend[b] && !clr[b]) m_ovf[b] = 1'b1;
            else if (bus.ovf_clr)             m_ovf[b] = 1'b0;
            nxt_pend[b] = rise ? 1'b1 : (clr[b] ? 1'b0 : m_pend[b]);
        end
        m_tmo = 0;
        if (!m_offering) begin
            if ((m_pend & ~bus.mask) != 4'b0) begin
                m_offering = 1;
                m_snap     = m_pend & ~bus.mask;
                m_age      = 1;
            end
        end else if (accepted) begin
            m_offering = 0;
        end else if (m_age == TMO_CYC) begin
            m_offering = 0;
            m_tmo      = 1;
        end else begin
            m_age++;
        end
        m_prev = bus.req_in;
        m_pend = nxt_pend;
    endtask

    // Compare outputs mid-cycle, advance the model, then cross the next edge.
    task automatic step();
        @(negedge clk);
        check("pend_valid", {3'b0, bus.pend_valid}, {3'b0, m_offering});
        check("pend_out", bus.pend_out, m_offering ? m_snap : 4'b0);
        check("ovf", bus.ovf, m_ovf);
        check("tmo", {3'b0, bus.tmo}, {3'b0, m_tmo});
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_in = '0; bus.mask = '0; bus.ack = 1'b0; bus.ack_idx = '0; bus.ovf_clr = 1'b0;
        model_reset();
        #1;
        check("rst_valid", {3'b0, bus.pend_valid}, 4'b0);
        check("rst_pout", bus.pend_out, 4'b0);
        check("rst_ovf", bus.ovf, 4'b0);
        check("rst_tmo", {3'b0, bus.tmo}, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single held request: offered two edges after the rise, acked, not re-offered
        bus.req_in = 4'b0010;
        step(); step();
        check("t1_valid", {3'b0, bus.pend_valid}, 4'b0001);
        check("t1_pout", bus.pend_out, 4'b0010);
        bus.ack = 1'b1; bus.ack_idx = 2'd1;
        step();
        bus.ack = 1'b0;
        repeat (4) step();
        check("t1_no_reoffer", {3'b0, bus.pend_valid}, 4'b0);
        bus.req_in = 4'b0000;
        step();

        // Back-to-back pulses on bits 2 and 3
        bus.req_in = 4'b0100; step();
        bus.req_in = 4'b1000; step();
        check("t2_snap", bus.pend_out, 4'b0100);
        bus.req_in = 4'b0000;
        bus.ack = 1'b1; bus.ack_idx = 2'd2; step();
        bus.ack = 1'b0; step();
        check("t2_next", bus.pend_out, 4'b1000);
        bus.ack = 1'b1; bus.ack_idx = 2'd3; step();
        bus.ack = 1'b0; step();

        // Masked request waits, then is offered once unmasked
        bus.mask = 4'b0010; bus.req_in = 4'b0010;
        repeat (3) step();
        check("t3_masked", {3'b0, bus.pend_valid}, 4'b0);
        bus.mask = 4'b0000; step();
        check("t3_unmasked", bus.pend_out, 4'b0010);
        bus.ack = 1'b1; bus.ack_idx = 2'd1; step();
        bus.ack = 1'b0; bus.req_in = 4'b0000; step();

        // Overflow set, clear, and edge coinciding with its own ack
        bus.req_in = 4'b0001; step();
        bus.req_in = 4'b0000; step();
        bus.req_in = 4'b0001; step();
        check("t4_ovf_set", bus.ovf, 4'b0001);
        bus.req_in = 4'b0000; bus.ovf_clr = 1'b1; step();
        bus.ovf_clr = 1'b0;
        check("t4_ovf_clr", bus.ovf, 4'b0000);
        bus.req_in = 4'b0001; bus.ack = 1'b1; bus.ack_idx = 2'd0; step();
        check("t4_no_ovf", bus.ovf, 4'b0000);
        bus.req_in = 4'b0000; bus.ack = 1'b0; step();
        check("t4_reoffer", bus.pend_out, 4'b0001);
        bus.ack = 1'b1; step();
        bus.ack = 1'b0; step();

        // Wrong-index ack ignored, then offer timeout and re-offer
        bus.req_in = 4'b0100; step();
        bus.req_in = 4'b0000; step();
        bus.ack = 1'b1; bus.ack_idx = 2'd0; step();
        bus.ack = 1'b0;
        check("t5_wrong_ack", {3'b0, bus.pend_valid}, 4'b0001);
        repeat (TMO_CYC - 1) step();
        check("t5_tmo", {3'b0, bus.tmo}, 4'b0001);
        check("t5_tmo_novalid", {3'b0, bus.pend_valid}, 4'b0);
        step();
        check("t5_reoffer", bus.pend_out, 4'b0100);
        check("t5_tmo_pulse", {3'b0, bus.tmo}, 4'b0);
        bus.ack = 1'b1; bus.ack_idx = 2'd2; step();
        bus.ack = 1'b0; step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] tog;
            for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 3) == 0);
            bus.req_in  = bus.req_in ^ tog;
            if ($urandom_range(0, 7) == 0) bus.mask = 4'($urandom_range(0, 15));
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.ack_idx = 2'($urandom_range(0, 3));
            bus.ovf_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        bus.ack = 1'b0; bus.ovf_clr = 1'b0; bus.mask = 4'b0000; bus.req_in = 4'b0000;

        // Asynchronous reset in the middle of an offer
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        bus.req_in = 4'b1111; step();
        bus.req_in = 4'b0000; step();
        bus.req_in = 4'b0001; step();
        check("t6_pre_valid", {3'b0, bus.pend_valid}, 4'b0001);
        check("t6_pre_pout", bus.pend_out, 4'b1111);
        check("t6_pre_ovf", bus.ovf, 4'b0001);
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", {3'b0, bus.pend_valid}, 4'b0);
        check("t6_async_pout", bus.pend_out, 4'b0);
        check("t6_async_ovf", bus.ovf, 4'b0);
        check("t6_async_tmo", {3'b0, bus.tmo}, 4'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
